// File: rtl/delivery_counter_25_pkg.sv
// Shared constants and the seven-segment lookup used by the delivery counter.
package delivery_counter_25_pkg;

  localparam int N_NODES_25 = 25;
  localparam int SEL_W      = 5;
  localparam int CNT_W      = 8;
  localparam int TOT_W      = 16;

  // Hex digit to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/delivery_counter_25_if.sv
// Board-facing signal bundle: router delivery bits, buttons, switch, display.
interface delivery_counter_25_if;
  import delivery_counter_25_pkg::*;

  logic [N_NODES_25-1:0] in_deliv;
  logic                  key_inc;
  logic                  key_dec;
  logic                  sw_clear;
  logic [SEL_W-1:0]      sel_node;
  logic [CNT_W-1:0]      cnt_out;
  logic                  sat_out;
  logic [TOT_W-1:0]      total_out;
  logic [6:0]            hex_lo;
  logic [6:0]            hex_hi;

  // Drives the board inputs and observes the display.
  modport master (
    output in_deliv, key_inc, key_dec, sw_clear,
    input  sel_node, cnt_out, sat_out, total_out, hex_lo, hex_hi
  );

  // The counter itself.
  modport slave (
    input  in_deliv, key_inc, key_dec, sw_clear,
    output sel_node, cnt_out, sat_out, total_out, hex_lo, hex_hi
  );
endinterface

// File: rtl/delivery_counter_25_hex7seg.sv
// One seven-segment digit decoder (active-low segments).
module delivery_counter_25_hex7seg
  import delivery_counter_25_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = seg7_decode(nib);

endmodule

// File: rtl/delivery_counter_25.sv
// Per-node delivery counters with network total and a button-selected
// node shown on two seven-segment digits.
module delivery_counter_25
  import delivery_counter_25_pkg::*;
#(
  parameter int N_NODES = N_NODES_25
)(
  input  logic                 clk,
  input  logic                 rst_n,
  delivery_counter_25_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_NODES - 1);

  logic [N_NODES-1:0] deliv_s1_q, deliv_s1_d;
  logic [N_NODES-1:0] deliv_s2_q, deliv_s2_d;
  logic [N_NODES-1:0] ev;
  logic [CNT_W-1:0]   cnt_q [N_NODES];
  logic [CNT_W-1:0]   cnt_d [N_NODES];
  logic [N_NODES-1:0] sat_q, sat_d;
  logic [TOT_W-1:0]   total_q, total_d, ev_sum;
  logic [2:0]         inc_sync_q, inc_sync_d, dec_sync_q, dec_sync_d;
  logic               inc_press, dec_press;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
  logic               sat_out_q, sat_out_d;

  // Two-stage delivery capture; an event is a rising edge between stages.
  always_comb begin
    deliv_s1_d = bus.in_deliv;
    deliv_s2_d = deliv_s1_q;
  end

  assign ev = deliv_s1_q & ~deliv_s2_q;

  // Delivery capture registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deliv_s1_q <= '0;
      deliv_s2_q <= '0;
    end else begin
      deliv_s1_q <= deliv_s1_d;
      deliv_s2_q <= deliv_s2_d;
    end
  end

  generate
    for (genvar gi = 0; gi < N_NODES; gi++) begin : g_node
      // Saturating per-node count; clear wins over a same-cycle event.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        sat_d[gi] = sat_q[gi];
        if (bus.sw_clear) begin
          cnt_d[gi] = '0;
          sat_d[gi] = 1'b0;
        end else if (ev[gi]) begin
          if (cnt_q[gi] == CNT_MAX) sat_d[gi] = 1'b1;
          else                      cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
        end
      end

      // Per-node count and sticky saturation flag.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q[gi] <= '0;
          sat_q[gi] <= 1'b0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
          sat_q[gi] <= sat_d[gi];
        end
      end
    end
  endgenerate

  // Network total: every event counts, saturated node or not; wraps.
  always_comb begin
    ev_sum = '0;
    for (int i = 0; i < N_NODES; i++) ev_sum = ev_sum + TOT_W'(ev[i]);
    total_d = bus.sw_clear ? '0 : total_q + ev_sum;
  end

  // Button synchronisers; stage 2 vs stage 3 yields a one-cycle press pulse.
  always_comb begin
    inc_sync_d = {inc_sync_q[1:0], bus.key_inc};
    dec_sync_d = {dec_sync_q[1:0], bus.key_dec};
    inc_press  = inc_sync_q[2] & ~inc_sync_q[1];
    dec_press  = dec_sync_q[2] & ~dec_sync_q[1];
  end

  // Node selection with wrap-around; simultaneous presses cancel.
  always_comb begin
    sel_d = sel_q;
    case ({inc_press, dec_press})
      2'b10:   sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
      2'b01:   sel_d = (sel_q == '0) ? SEL_MAX : sel_q - SEL_W'(1);
      default: sel_d = sel_q;
    endcase
    cnt_out_d = cnt_q[sel_q];
    sat_out_d = sat_q[sel_q];
  end

  // Total, key, selection and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q    <= '0;
      inc_sync_q <= '1;
      dec_sync_q <= '1;
      sel_q      <= '0;
      cnt_out_q  <= '0;
      sat_out_q  <= 1'b0;
    end else begin
      total_q    <= total_d;
      inc_sync_q <= inc_sync_d;
      dec_sync_q <= dec_sync_d;
      sel_q      <= sel_d;
      cnt_out_q  <= cnt_out_d;
      sat_out_q  <= sat_out_d;
    end
  end

  logic [6:0] seg_lo, seg_hi;

  delivery_counter_25_hex7seg u_hex_lo (.nib(cnt_out_q[3:0]), .seg(seg_lo));
  delivery_counter_25_hex7seg u_hex_hi (.nib(cnt_out_q[7:4]), .seg(seg_hi));

  assign bus.sel_node  = sel_q;
  assign bus.cnt_out   = cnt_out_q;
  assign bus.sat_out   = sat_out_q;
  assign bus.total_out = total_q;
  assign bus.hex_lo    = seg_lo;
  assign bus.hex_hi    = seg_hi;

endmodule
